// File: rtl/usb_pkt_tx.sv
// Purpose: serialises USB handshake, token and data packets onto DP/DM with bit stuffing, NRZI and EOP.
// Latency: first SYNC bit reaches DP/DM one clock after start is accepted; one line bit per clock after that.
// Backpressure: none; start is honoured only in IDLE, and busy covers the whole packet including EOP.
module usb_pkt_tx #(
    parameter int MAX_BYTES    = 8,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [1:0]                     pkt_type,
    input  logic [3:0]                     pid,
    input  logic [6:0]                     addr,
    input  logic [3:0]                     endp,
    input  logic [8*MAX_BYTES-1:0]         data,
    input  logic [$clog2(MAX_BYTES+1)-1:0] nbytes,
    output logic                           busy,
    output logic                           done,
    output logic                           DP,
    output logic                           DM
);
    localparam int NBW = $clog2(MAX_BYTES + 1);
    localparam int DW  = 8 * MAX_BYTES;
    localparam int DIW = $clog2(DW);
    localparam int CW  = $clog2(DW + 17);

    typedef enum logic [3:0] {
        ST_IDLE, ST_SYNC, ST_PID, ST_ADDR, ST_ENDP,
        ST_CRC5, ST_DATA, ST_CRC16, ST_EOP_SE0, ST_EOP_J
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       ones_q, ones_d;
    logic             lvl_q, lvl_d;
    logic [4:0]       crc5_q, crc5_d;
    logic [15:0]      crc16_q, crc16_d;
    logic [1:0]       type_q, type_d;
    logic [3:0]       pid_q, pid_d;
    logic [6:0]       addr_q, addr_d;
    logic [3:0]       endp_q, endp_d;
    logic [DW-1:0]    data_q, data_d;
    logic [NBW-1:0]   nbytes_q, nbytes_d;
    logic             dp_q, dp_d;
    logic             dm_q, dm_d;
    logic             done_q, done_d;

    logic             fbit;
    logic [CW-1:0]    flen;
    state_t           fnext;
    logic             flast;
    logic             tx_bit;
    logic [CW-1:0]    cnt_inc;
    logic [7:0]       pid_bits;
    logic [4:0]       crc5_nxt;
    logic [15:0]      crc16_nxt;

    assign cnt_inc   = cnt_q + CW'(1);
    assign pid_bits  = {~pid_q, pid_q};
    assign crc5_nxt  = {crc5_q[3:0], 1'b0} ^ ((fbit ^ crc5_q[4]) ? 5'b00101 : 5'b00000);
    assign crc16_nxt = {crc16_q[14:0], 1'b0} ^ ((fbit ^ crc16_q[15]) ? 16'h8005 : 16'h0000);

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign DP   = dp_q;
    assign DM   = dm_q;

    // Current field: its next raw bit, its length, the field that follows, and whether EOP follows it.
    always_comb begin
        fbit  = 1'b0;
        flen  = CW'(8);
        fnext = ST_EOP_SE0;
        flast = 1'b0;
        case (state_q)
            ST_SYNC: begin
                fbit  = (cnt_q == CW'(7));
                fnext = ST_PID;
            end
            ST_PID: begin
                fbit = pid_bits[cnt_q[2:0]];
                case (type_q)
                    2'd1:    fnext = ST_ADDR;
                    2'd2:    fnext = (nbytes_q == '0) ? ST_CRC16 : ST_DATA;
                    default: flast = 1'b1;
                endcase
            end
            ST_ADDR: begin
                fbit  = addr_q[cnt_q[2:0]];
                flen  = CW'(7);
                fnext = ST_ENDP;
            end
            ST_ENDP: begin
                fbit  = endp_q[cnt_q[1:0]];
                flen  = CW'(4);
                fnext = ST_CRC5;
            end
            ST_CRC5: begin
                fbit  = ~crc5_q[3'd4 - cnt_q[2:0]];
                flen  = CW'(5);
                flast = 1'b1;
            end
            ST_DATA: begin
                fbit  = data_q[cnt_q[DIW-1:0]];
                flen  = CW'({nbytes_q, 3'b000});
                fnext = ST_CRC16;
            end
            ST_CRC16: begin
                fbit  = ~crc16_q[4'd15 - cnt_q[3:0]];
                flen  = CW'(16);
                flast = 1'b1;
            end
            default: ;
        endcase
    end

    // Sequencer: field walk, stuff insertion, CRC accumulation, NRZI and EOP line levels.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ones_d   = ones_q;
        lvl_d    = lvl_q;
        crc5_d   = crc5_q;
        crc16_d  = crc16_q;
        type_d   = type_q;
        pid_d    = pid_q;
        addr_d   = addr_q;
        endp_d   = endp_q;
        data_d   = data_q;
        nbytes_d = nbytes_q;
        dp_d     = 1'b1;
        dm_d     = 1'b0;
        done_d   = 1'b0;
        tx_bit   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                lvl_d  = 1'b1;
                ones_d = '0;
                cnt_d  = '0;
                if (start) begin
                    type_d   = pkt_type;
                    pid_d    = pid;
                    addr_d   = addr;
                    endp_d   = endp;
                    data_d   = data;
                    nbytes_d = (nbytes > NBW'(MAX_BYTES)) ? NBW'(MAX_BYTES) : nbytes;
                    crc5_d   = 5'h1F;
                    crc16_d  = 16'hFFFF;
                    state_d  = ST_SYNC;
                end
            end
            ST_EOP_SE0: begin
                dp_d  = 1'b0;
                lvl_d = 1'b1;
                if (cnt_q == CW'(EOP_SE0_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_EOP_J;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_EOP_J: begin
                lvl_d   = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                if (ones_q == 3'd6) begin
                    // Stuffed zero: field position and CRC hold. cnt_q == flen only when the
                    // six-1 run ended on the final bit before EOP, so EOP follows this bit.
                    tx_bit = 1'b0;
                    ones_d = '0;
                    if (cnt_q == flen) begin
                        cnt_d   = '0;
                        state_d = ST_EOP_SE0;
                    end
                end else begin
                    tx_bit = fbit;
                    ones_d = fbit ? ones_q + 3'd1 : 3'd0;
                    if (state_q == ST_ADDR || state_q == ST_ENDP) crc5_d = crc5_nxt;
                    if (state_q == ST_DATA) crc16_d = crc16_nxt;
                    if (cnt_inc == flen) begin
                        if (flast && fbit && ones_q == 3'd5) begin
                            cnt_d = cnt_inc;
                        end else begin
                            cnt_d   = '0;
                            state_d = fnext;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                lvl_d = tx_bit ? lvl_q : ~lvl_q;
                dp_d  = lvl_d;
                dm_d  = ~lvl_d;
            end
        endcase
    end

    // State and output registers with synchronous reset to an idle J line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ones_q   <= '0;
            lvl_q    <= 1'b1;
            crc5_q   <= '0;
            crc16_q  <= '0;
            type_q   <= '0;
            pid_q    <= '0;
            addr_q   <= '0;
            endp_q   <= '0;
            data_q   <= '0;
            nbytes_q <= '0;
            dp_q     <= 1'b1;
            dm_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ones_q   <= ones_d;
            lvl_q    <= lvl_d;
            crc5_q   <= crc5_d;
            crc16_q  <= crc16_d;
            type_q   <= type_d;
            pid_q    <= pid_d;
            addr_q   <= addr_d;
            endp_q   <= endp_d;
            data_q   <= data_d;
            nbytes_q <= nbytes_d;
            dp_q     <= dp_d;
            dm_q     <= dm_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: doc/usb_pkt_tx.md
USB_PKT_TX -- requirements
Module: usb_pkt_tx

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 8: maximum data-packet payload in bytes (1..64).
REQ-002 SHALL have parameter EOP_SE0_BITS, default 2: SE0 cycles in end-of-packet.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on posedge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1: request to send a packet; sampled only in IDLE.
REQ-006 SHALL have port pkt_type  input  2: 0 handshake, 1 token, 2 data, 3 reserved (treated as handshake).
REQ-007 SHALL have port pid  input  4: PID value; the check nibble is generated internally.
REQ-008 SHALL have port addr  input  7: token device address.
REQ-009 SHALL have port endp  input  4: token endpoint.
REQ-010 SHALL have port data  input  8*MAX_BYTES: payload; byte k at data[8k+7:8k].
REQ-011 SHALL have port nbytes  input  $clog2(MAX_BYTES+1): payload length; values above MAX_BYTES clamp to MAX_BYTES.
REQ-012 SHALL have port busy  output  1: high from the cycle after start is accepted until done.
REQ-013 SHALL have port done  output  1: one-cycle pulse when the packet completes.
REQ-014 SHALL have ports DP, DM  output  1 each: registered bus lines.

Function
REQ-015 In IDLE the block SHALL drive J (DP=1, DM=0) with busy=0 and done=0.
REQ-016 When start=1 in IDLE, the block SHALL latch pkt_type, pid, addr, endp, data and nbytes; later input changes SHALL have no effect.
REQ-017 The block SHALL ignore start while busy=1.
REQ-018 The block SHALL place the first SYNC line bit on DP/DM at the second posedge after start is sampled, and SHALL send one bit per clock.
REQ-019 The FSM SHALL have states IDLE, SYNC, PID, ADDR, ENDP, CRC5, DATA, CRC16, EOP_SE0 and EOP_J.
REQ-020 Handshake packets SHALL go SYNC->PID->EOP_SE0; token packets SYNC->PID->ADDR->ENDP->CRC5->EOP_SE0; data packets SYNC->PID->DATA->CRC16->EOP_SE0, skipping DATA when nbytes=0.
REQ-021 SYNC SHALL be the 8 bits 0,0,0,0,0,0,0,1.
REQ-022 PID SHALL be pid[0..3] then ~pid[0..3], LSB first.
REQ-023 addr, endp and data bytes SHALL be sent LSB first, with byte 0 first.
REQ-024 CRC5 SHALL use polynomial x^5+x^2+1 over addr and endp, initialised to 5'b11111, and be sent complemented, MSB first.
REQ-025 CRC16 SHALL use polynomial 0x8005 over the payload, initialised to 16'hFFFF, and be sent complemented, MSB first; nbytes=0 SHALL yield 16 zero bits.
REQ-026 Bit stuffing SHALL count consecutive 1s in the pre-NRZI stream from the first SYNC bit through the last CRC bit.
REQ-027 After six consecutive 1s the block SHALL insert one 0, which consumes a cycle, freezes field counters and CRC update, and resets the run count.
REQ-028 If a six-1 run ends on the last CRC bit, the stuffed 0 SHALL be sent before EOP.
REQ-029 NRZI encoding SHALL make a 0 toggle the line (J<->K) and a 1 hold it, with the level before the first SYNC bit being J; K is DP=0, DM=1.
REQ-030 EOP SHALL be SE0 (DP=0, DM=0) for EOP_SE0_BITS cycles, then J for one cycle (EOP_J), with no stuffing or NRZI.
REQ-031 On leaving EOP_J, done=1 for exactly that one cycle, busy=0, and the state SHALL be IDLE.
REQ-032 Busy duration SHALL equal total bits + stuffed bits + EOP_SE0_BITS + 1 cycles.
REQ-033 The block SHALL accept a start asserted in the same cycle that done=1; the next packet follows with no extra idle cycle.

Reset
REQ-034 While rst=1 at a posedge, the block SHALL enter IDLE with DP=1, DM=0, busy=0 and done=0, and SHALL clear the stuff counter, CRC registers, NRZI level and latched fields.
REQ-035 Reset in any state, including mid-field or mid-EOP, SHALL abort the packet with no done pulse; the first start after rst deasserts SHALL behave as from power-up.

Verification
REQ-036 The bench SHALL send a handshake with pid=4'b0010 (ACK): decoded bits SHALL be 00000001 01001011, there SHALL be no stuff bits, busy SHALL be high 19 cycles, and done SHALL pulse once.
REQ-037 The bench SHALL send a token with pid=4'b0001 (OUT), addr=7'h05, endp=4'h4: the decoder SHALL recover addr/endp, and the CRC5 residual over addr, endp and CRC SHALL equal 5'b01100.
REQ-038 The bench SHALL send data with pid=4'b0011, nbytes=8, data=64'h1010101010101010: the decoder SHALL recover all 8 bytes, and the CRC16 residual SHALL equal 16'h800D.
REQ-039 The bench SHALL send data with nbytes=2, data=16'hFFFF: a 0 SHALL follow every run of six 1s, no run of seven 1s SHALL appear on the wire, and the destuffed payload SHALL be FF FF.
REQ-040 The bench SHALL assert rst for one cycle while in DATA: the next cycle SHALL show DP=1, DM=0, busy=0, done SHALL never pulse, and a following ACK SHALL be sent correctly.
REQ-041 The bench SHALL pulse start with new fields while busy: this SHALL be ignored; nbytes=0 SHALL send a CRC16 field of 16 zero bits, and nbytes=MAX_BYTES+1 SHALL send MAX_BYTES bytes.
